// File: rtl/polyvecl_gamma1_sched.sv
// rtl/polyvecl_gamma1_sched.sv - sequences L gamma1 sampling runs over one shared engine
// Optional watchdog on each engine run: GAMMA1_SCHED_TIMEOUT_EN
module polyvecl_gamma1_sched #(
  parameter int L              = 4,
  parameter int NONCE_W        = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [511:0]       seed,
  input  logic [15:0]        kappa,
  output logic               busy,
  output logic               eng_start,
  output logic [511:0]       eng_seed,
  output logic [NONCE_W-1:0] eng_nonce,
  input  logic               eng_done,
  output logic               poly_valid,
  input  logic               poly_ready,
  output logic [2:0]         poly_idx,
  output logic               done,
  output logic               err
);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_PRESENT, S_GAP, S_DONE} state_e;

  localparam logic [2:0] LAST_IDX = 3'(L - 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               eng_start_q, eng_start_d;
  logic               poly_valid_q, poly_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               gap_q, gap_d;
  logic [511:0]       seed_q, seed_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [2:0]         idx_q, idx_d;
  logic [NONCE_W-1:0] base_nonce;

  assign base_nonce = NONCE_W'(L * kappa);

`ifdef GAMMA1_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // TIMEOUT_CYCLES has no effect without the watchdog compiled in
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    eng_start_d  = eng_start_q;
    poly_valid_d = poly_valid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    gap_d        = gap_q;
    seed_d       = seed_q;
    nonce_d      = nonce_q;
    idx_d        = idx_q;
`ifdef GAMMA1_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d      = seed;
          nonce_d     = base_nonce;
          idx_d       = 3'd0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          eng_start_d = 1'b1;
          state_d     = S_LAUNCH;
`ifdef GAMMA1_SCHED_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_LAUNCH: begin
        if (eng_done) begin
          eng_start_d  = 1'b0;
          poly_valid_d = 1'b1;
          state_d      = S_PRESENT;
        end
`ifdef GAMMA1_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d       = 1'b1;
          eng_start_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_PRESENT: begin
        if (poly_ready) begin
          poly_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            nonce_d = nonce_q + 1'b1;
            gap_d   = 1'b0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // two idle cycles let the engine fall back to its idle state
        if (gap_q) begin
          eng_start_d = 1'b1;
          state_d     = S_LAUNCH;
`ifdef GAMMA1_SCHED_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else begin
          gap_d = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      eng_start_q  <= 1'b0;
      poly_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      gap_q        <= 1'b0;
      seed_q       <= '0;
      nonce_q      <= '0;
      idx_q        <= 3'd0;
`ifdef GAMMA1_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      eng_start_q  <= eng_start_d;
      poly_valid_q <= poly_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      gap_q        <= gap_d;
      seed_q       <= seed_d;
      nonce_q      <= nonce_d;
      idx_q        <= idx_d;
`ifdef GAMMA1_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign eng_start  = eng_start_q;
  assign eng_seed   = seed_q;
  assign eng_nonce  = nonce_q;
  assign poly_valid = poly_valid_q;
  assign poly_idx   = idx_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule
